// File: rtl/dma_mem_responder.sv
// Burst memory responder: read data valid one cycle after request accept, done pulses len+1 cycles after accept (1 for zero-length).
// Read beats hold under rdata_ready=0; `DMA_MEM_RESPONDER_BEAT_CNT_EN adds a saturating beat_count output.
module dma_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [SIZE_WIDTH-1:0] req_len,
  input  logic                  req_write,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  done,
  output logic                  done_err
`ifdef DMA_MEM_RESPONDER_BEAT_CNT_EN
  ,
  output logic [31:0]           beat_count
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [SIZE_WIDTH-1:0]   rem_q;
  logic [SIZE_WIDTH-1:0]   rem_d;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rvld_q;
  logic                    rlast_q;
  logic                    done_q;
  logic                    err_q;
  logic                    req_rdy_q;
  logic                    wrdy_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    req_fire;
  logic                    wr_fire;
  logic                    rd_fire;
  logic                    rd_load;

  assign req_fire = req_valid && req_rdy_q;
  assign wr_fire  = wdata_valid && wrdy_q;
  assign rd_fire  = rvld_q && rdata_ready;
  // Refill the output register whenever it is empty or being drained this edge.
  assign rd_load  = (state_q == READ) && (rem_q != '0) && (!rvld_q || rdata_ready);

  // Address wraps silently at the top of memory.
  assign addr_d = addr_q + ADDR_WIDTH'(1);
  assign rem_d  = rem_q - SIZE_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      rdata_q   <= '0;
      rvld_q    <= 1'b0;
      rlast_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      req_rdy_q <= 1'b1;
      wrdy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            req_rdy_q <= 1'b0;
            addr_q    <= req_addr;
            rem_q     <= req_len;
            if (req_len == '0) begin
              state_q <= RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (req_write) begin
              state_q <= WRITE;
              wrdy_q  <= 1'b1;
            end else begin
              // First beat is fetched on the accept edge so it is valid the next cycle.
              state_q <= READ;
              rdata_q <= mem[req_addr];
              rvld_q  <= 1'b1;
              rlast_q <= (req_len == SIZE_WIDTH'(1));
              addr_q  <= req_addr + ADDR_WIDTH'(1);
              rem_q   <= req_len - SIZE_WIDTH'(1);
            end
          end
        end
        READ: begin
          if (rd_load) begin
            rdata_q <= mem[addr_q];
            rvld_q  <= 1'b1;
            rlast_q <= (rem_q == SIZE_WIDTH'(1));
            addr_q  <= addr_d;
            rem_q   <= rem_d;
          end else if (rd_fire) begin
            rvld_q  <= 1'b0;
            rlast_q <= 1'b0;
            state_q <= RESP;
            done_q  <= 1'b1;
          end
        end
        WRITE: begin
          if (wr_fire) begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            if (rem_q == SIZE_WIDTH'(1)) begin
              state_q <= RESP;
              wrdy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        RESP: begin
          state_q   <= IDLE;
          req_rdy_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          req_rdy_q <= 1'b1;
          wrdy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Memory is deliberately not reset so writes survive an aborted burst.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[addr_q] <= wdata;
    end
  end

  assign req_ready   = req_rdy_q;
  assign wdata_ready = wrdy_q;
  assign rdata_valid = rvld_q;
  assign rdata       = rdata_q;
  assign rdata_last  = rlast_q;
  assign done        = done_q;
  assign done_err    = err_q;

`ifdef DMA_MEM_RESPONDER_BEAT_CNT_EN
  logic [31:0] beat_cnt_q;
  logic [31:0] beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if ((rd_fire || wr_fire) && (beat_cnt_q != '1)) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_count = beat_cnt_q;
`endif

endmodule
